keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad: drives one column low at a time and reads the four row lines back.
- Debounces the result over whole scans and reports one debounced key as a code with a single-cycle valid strobe.
- Mirrors the display refresher's column-multiplexing scheme in the input direction, and sits between the board keypad pins and user logic on the same clock.

---
 rtl/keypad_scanner_if.sv | 24 ++
 rtl/keypad_scanner.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pin and debounced key bundle for keypad_scanner
interface keypad_scanner_if;
  logic [3:0] Rows;
  logic [3:0] Columns;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyHeld;

  modport master (
    input  Rows,
    output Columns,
    output KeyCode,
    output KeyValid,
    output KeyHeld
  );

  modport slave (
    output Rows,
    input  Columns,
    input  KeyCode,
    input  KeyValid,
    input  KeyHeld
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with whole-scan debounce
// One column is driven low per step; rows are sampled at the end of each step.
module keypad_scanner #(
  parameter int Divider       = 10000,
  parameter int NumberOfBits  = 14,
  parameter int DebounceScans = 3
) (
  input  logic              CLOCK,
  input  logic              Reset,
  keypad_scanner_if.master  bus
);

  localparam logic [NumberOfBits-1:0] DIV_END = NumberOfBits'(Divider);
  localparam logic [NumberOfBits-1:0] CNT_ONE = NumberOfBits'(1);
  localparam int                      SW      = $clog2(DebounceScans + 1);
  localparam logic [SW-1:0]           STABLE_DONE = SW'(DebounceScans);
  localparam logic [SW-1:0]           STABLE_ONE  = SW'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESS   = 2'd1;
  localparam logic [1:0] S_HELD    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [NumberOfBits-1:0] count;
  logic                    tick;
  logic                    end_of_scan;
  logic [1:0]              col;
  logic [3:0]              rows_meta;
  logic [3:0]              rows_sync;

  logic [3:0] row_low;
  logic       sample_none;
  logic       sample_single;
  logic [1:0] sample_row;

  logic       acc_key;
  logic       acc_bad;
  logic [3:0] acc_code;
  logic       base_key;
  logic       base_bad;
  logic [3:0] base_code;
  logic       scan_key;
  logic       scan_bad;
  logic [3:0] scan_code;
  logic       scan_is_none;
  logic       scan_is_key;

  logic [1:0]    state;
  logic [SW-1:0] stable;
  logic [SW-1:0] stable_next;
  logic [3:0]    candidate;
  logic [3:0]    key_code;
  logic          key_valid;

  assign tick        = (count == DIV_END);
  assign end_of_scan = tick && (col == 2'd3);
  assign stable_next = stable + STABLE_ONE;

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
      col   <= 2'd0;
    end else if (tick) begin
      count <= '0;
      col   <= col + 2'd1;
    end else begin
      count <= count + CNT_ONE;
    end
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      rows_meta <= 4'b1111;
      rows_sync <= 4'b1111;
    end else begin
      rows_meta <= bus.Rows;
      rows_sync <= rows_meta;
    end
  end

  always_comb begin
    row_low       = ~rows_sync;
    sample_none   = (row_low == 4'd0);
    sample_single = !sample_none && ((row_low & (row_low - 4'd1)) == 4'd0);
    sample_row    = 2'd0;
    case (row_low)
      4'b0001: sample_row = 2'd0;
      4'b0010: sample_row = 2'd1;
      4'b0100: sample_row = 2'd2;
      4'b1000: sample_row = 2'd3;
      default: sample_row = 2'd0;
    endcase
  end

  // Column 0 starts a fresh scan, so the accumulator is ignored there.
  always_comb begin
    base_key  = (col == 2'd0) ? 1'b0 : acc_key;
    base_bad  = (col == 2'd0) ? 1'b0 : acc_bad;
    base_code = (col == 2'd0) ? 4'd0 : acc_code;
    scan_key  = base_key | sample_single;
    scan_bad  = base_bad | (!sample_none && !sample_single) | (sample_single && base_key);
    scan_code = sample_single ? {col, sample_row} : base_code;
    scan_is_none = !scan_key && !scan_bad;
    scan_is_key  = scan_key && !scan_bad;
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      acc_key  <= 1'b0;
      acc_bad  <= 1'b0;
      acc_code <= 4'd0;
    end else if (tick) begin
      acc_key  <= scan_key;
      acc_bad  <= scan_bad;
      acc_code <= scan_code;
    end
  end

  always_ff @(posedge CLOCK or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      stable    <= '0;
      candidate <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (end_of_scan) begin
        case (state)
          S_IDLE: begin
            if (scan_is_key) begin
              state     <= S_PRESS;
              candidate <= scan_code;
              stable    <= STABLE_ONE;
            end
          end
          S_PRESS: begin
            if (scan_is_key && (scan_code == candidate)) begin
              if (stable_next == STABLE_DONE) begin
                state     <= S_HELD;
                stable    <= '0;
                key_code  <= candidate;
                key_valid <= 1'b1;
              end else begin
                stable <= stable_next;
              end
            end else if (scan_is_key) begin
              candidate <= scan_code;
              stable    <= STABLE_ONE;
            end else begin
              state  <= S_IDLE;
              stable <= '0;
            end
          end
          // No rollover: any non-empty scan keeps the accepted key held.
          S_HELD: begin
            if (scan_is_none) begin
              state  <= S_RELEASE;
              stable <= STABLE_ONE;
            end
          end
          S_RELEASE: begin
            if (scan_is_none) begin
              if (stable_next == STABLE_DONE) begin
                state  <= S_IDLE;
                stable <= '0;
              end else begin
                stable <= stable_next;
              end
            end else begin
              state  <= S_HELD;
              stable <= '0;
            end
          end
          default: begin
            state  <= S_IDLE;
            stable <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    case (col)
      2'd0:    bus.Columns = 4'b1110;
      2'd1:    bus.Columns = 4'b1101;
      2'd2:    bus.Columns = 4'b1011;
      default: bus.Columns = 4'b0111;
    endcase
  end

  assign bus.KeyCode  = key_code;
  assign bus.KeyValid = key_valid;
  assign bus.KeyHeld  = (state == S_HELD) || (state == S_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with key-code scoreboard
module tb_keypad_scanner;
  logic        clk;
  logic        rst_n;
  logic [15:0] keys;
  logic [3:0]  rows;
  int          checks;
  int          errors;
  logic [3:0]  sb[$];
  logic [3:0]  col_exp[4];

  keypad_scanner_if bus ();

  keypad_scanner #(
    .Divider(3),
    .NumberOfBits(4),
    .DebounceScans(3)
  ) dut (
    .CLOCK(clk),
    .Reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a pressed key (c,r) pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!bus.Columns[c] && keys[c*4+r]) rows[r] = 1'b0;
  end
  assign bus.Rows = rows;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic monitor();
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (bus.KeyValid === 1'b1) begin
        if (sb.size() == 0) begin
          check("extra_pulse", {7'd0, bus.KeyValid}, 8'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_code", {4'd0, bus.KeyCode}, {4'd0, e});
          check("pulse_held", {7'd0, bus.KeyHeld}, 8'd1);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    keys   = 16'd0;
    rst_n  = 1'b1;
    col_exp[0] = 4'b1110;
    col_exp[1] = 4'b1101;
    col_exp[2] = 4'b1011;
    col_exp[3] = 4'b0111;
    fork
      monitor();
    join_none

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_columns", {4'd0, bus.Columns}, 8'h0E);
    check("rst_code", {4'd0, bus.KeyCode}, 8'd0);
    check("rst_valid", {7'd0, bus.KeyValid}, 8'd0);
    check("rst_held", {7'd0, bus.KeyHeld}, 8'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      check("rotate", {4'd0, bus.Columns}, {4'd0, col_exp[k/4]});
      @(negedge clk);
    end
    check("rotate_wrap", {4'd0, bus.Columns}, 8'h0E);

    // Clean press of (2,1) -> code 9
    keys[9] = 1'b1;
    sb.push_back(4'd9);
    scans(2);
    repeat (15) @(negedge clk);
    check("clean_not_early", {7'd0, bus.KeyValid}, 8'd0);
    @(negedge clk);
    check("clean_valid", {7'd0, bus.KeyValid}, 8'd1);
    check("clean_code", {4'd0, bus.KeyCode}, 8'd9);
    scans(2);
    check("clean_still_held", {7'd0, bus.KeyHeld}, 8'd1);
    keys = 16'd0;
    scans(3);
    check("clean_released", {7'd0, bus.KeyHeld}, 8'd0);

    // Press bounce on (0,3) -> code 3
    keys[3] = 1'b1;
    scans(2);
    keys = 16'd0;
    scans(1);
    check("bounce_no_held", {7'd0, bus.KeyHeld}, 8'd0);
    keys[3] = 1'b1;
    sb.push_back(4'd3);
    scans(3);
    check("bounce_valid", {7'd0, bus.KeyValid}, 8'd1);
    check("bounce_code", {4'd0, bus.KeyCode}, 8'd3);
    keys = 16'd0;
    scans(3);
    check("bounce_released", {7'd0, bus.KeyHeld}, 8'd0);

    // Two keys (1,0) and (3,2): ghost/invalid until (3,2) lifts
    keys[4]  = 1'b1;
    keys[14] = 1'b1;
    scans(5);
    check("two_keys_held", {7'd0, bus.KeyHeld}, 8'd0);
    check("two_keys_code", {4'd0, bus.KeyCode}, 8'd3);
    keys[14] = 1'b0;
    sb.push_back(4'd4);
    scans(3);
    check("single_valid", {7'd0, bus.KeyValid}, 8'd1);
    check("single_code", {4'd0, bus.KeyCode}, 8'd4);

    // Release bounce while (1,0) is held
    keys = 16'd0;
    scans(1);
    keys[4] = 1'b1;
    scans(1);
    check("relbounce_held", {7'd0, bus.KeyHeld}, 8'd1);
    keys = 16'd0;
    scans(2);
    repeat (15) @(negedge clk);
    check("release_not_early", {7'd0, bus.KeyHeld}, 8'd1);
    @(negedge clk);
    check("release_done", {7'd0, bus.KeyHeld}, 8'd0);
    check("release_code_kept", {4'd0, bus.KeyCode}, 8'd4);

    // Reset during the second press scan of (2,1)
    keys[9] = 1'b1;
    scans(1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_columns", {4'd0, bus.Columns}, 8'h0E);
    check("midrst_code", {4'd0, bus.KeyCode}, 8'd0);
    check("midrst_valid", {7'd0, bus.KeyValid}, 8'd0);
    check("midrst_held", {7'd0, bus.KeyHeld}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(4'd9);
    scans(2);
    repeat (15) @(negedge clk);
    check("midrst_not_early", {7'd0, bus.KeyValid}, 8'd0);
    @(negedge clk);
    check("midrst_valid_after", {7'd0, bus.KeyValid}, 8'd1);
    check("midrst_code_after", {4'd0, bus.KeyCode}, 8'd9);
    scans(1);

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
